// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA raster generator:
//   - default 640x480@60 timing constants (50 MHz sysclk, pixel tick = /2)
//   - total(): line/frame length from active + porches + sync
//   - coord_w(): clog2-based width of a counter spanning 0..tot-1 (min 1 bit)
//   - rgb_def_t: {R,G,B} colour struct at the default channel width; modules
//     built with another COLOR_W declare the same {r,g,b} layout at their width
// Optional feature macro used by the top: VGA_TESTPATTERN_EN
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int CLK_DIV_DEF  = 2;
  localparam int COLOR_W_DEF  = 1;

  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int coord_w(input int tot);
    return (tot > 1) ? $clog2(tot) : 1;
  endfunction

  localparam int H_TOTAL_DEF = total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);
  localparam int H_W_DEF     = coord_w(H_TOTAL_DEF);
  localparam int V_W_DEF     = coord_w(V_TOTAL_DEF);

  typedef struct packed {
    logic [COLOR_W_DEF-1:0] r;
    logic [COLOR_W_DEF-1:0] g;
    logic [COLOR_W_DEF-1:0] b;
  } rgb_def_t;

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis (horizontal or vertical): a 0..TOTAL-1 counter with wrap,
// active-area and sync-window decode of the current count.
// Ports:
//   clk_i        clock
//   clear_i      synchronous clear to 0 (reset / raster halt)
//   count_en_i   advance one step this cycle
//   count_o      current count
//   wrap_o       count is TOTAL-1 (next step returns to 0)
//   active_o     count < ACTIVE
//   sync_win_o   ACTIVE+FP <= count < ACTIVE+FP+SYNC
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF,
  parameter int W      = coord_w(total(ACTIVE, FP, SYNC, BP))
) (
  input  logic         clk_i,
  input  logic         clear_i,
  input  logic         count_en_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o,
  output logic         active_o,
  output logic         sync_win_o
);

  localparam int TOTAL = total(ACTIVE, FP, SYNC, BP);

  // Window bounds held one bit wider so an end bound equal to TOTAL cannot
  // alias to 0 when TOTAL is a power of two.
  localparam logic [W:0] ACT_END   = (W+1)'(ACTIVE);
  localparam logic [W:0] SYNC_BEG  = (W+1)'(ACTIVE + FP);
  localparam logic [W:0] SYNC_END  = (W+1)'(ACTIVE + FP + SYNC);
  localparam logic [W:0] LAST      = (W+1)'(TOTAL - 1);

  logic [W-1:0] count_q, count_d;
  logic [W:0]   count_x;

  assign count_x = {1'b0, count_q};

  assign wrap_o     = (count_x == LAST);
  assign active_o   = (count_x < ACT_END);
  assign sync_win_o = (count_x >= SYNC_BEG) && (count_x < SYNC_END);
  assign count_o    = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_en_i) begin
      count_d = wrap_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster generator. sysclk is divided into a pixel tick; H/V
// counters publish the coordinate being requested from an upstream pixel
// source, whose colour is registered one tick later onto VGA_R/G/B together
// with the matching VGA_HS/VGA_VS.
// Optional feature: define VGA_TESTPATTERN_EN to add pattern_sel and an
// internal 8-vertical-bar test pattern.
// Ports:
//   sysclk       system clock (single domain)
//   rst          synchronous active-high reset
//   enable       raster run; low clears and holds the raster, restart at (0,0)
//   rgb_in       {R,G,B} for the previously published coordinate
//   pattern_sel  selects the test pattern (VGA_TESTPATTERN_EN only)
//   px_x/px_y    coordinate being requested
//   px_valid     px_x/px_y inside the active area
//   frame_start  one-cycle pulse when (0,0) is published
//   VGA_R/G/B    registered colour
//   VGA_HS/VS    registered syncs, aligned with colour
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int COLOR_W  = COLOR_W_DEF
) (
  input  logic                                                sysclk,
  input  logic                                                rst,
  input  logic                                                enable,
  input  logic [3*COLOR_W-1:0]                                rgb_in,
`ifdef VGA_TESTPATTERN_EN
  input  logic                                                pattern_sel,
`endif
  output logic [coord_w(total(H_ACTIVE,H_FP,H_SYNC,H_BP))-1:0] px_x,
  output logic [coord_w(total(V_ACTIVE,V_FP,V_SYNC,V_BP))-1:0] px_y,
  output logic                                                px_valid,
  output logic                                                frame_start,
  output logic [COLOR_W-1:0]                                  VGA_R,
  output logic [COLOR_W-1:0]                                  VGA_G,
  output logic [COLOR_W-1:0]                                  VGA_B,
  output logic                                                VGA_HS,
  output logic                                                VGA_VS
);

  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = coord_w(H_TOTAL);
  localparam int VW      = coord_w(V_TOTAL);
  localparam int DIV_W   = coord_w(CLK_DIV);

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } pix_t;

  logic [DIV_W-1:0] div_q, div_d;
  logic             run_q, run_d;   // a coordinate has been published since halt
  logic             fs_q, fs_d;
  pix_t             col_q, col_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;

  logic             halt;
  logic             tick;
  logic [HW-1:0]    h_count;
  logic [VW-1:0]    v_count;
  logic             h_wrap, h_active, h_sync_win;
  logic             v_wrap, v_active, v_sync_win;
  logic             pix_valid;
  pix_t             src;

  assign halt = rst | ~enable;
  assign tick = (div_q == DIV_W'(CLK_DIV - 1));

  // The first tick after a halt publishes (0,0) without stepping, so the
  // counters only advance once a coordinate is already on display.
  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (HW)
  ) u_h_axis (
    .clk_i      (sysclk),
    .clear_i    (halt),
    .count_en_i (tick & run_q),
    .count_o    (h_count),
    .wrap_o     (h_wrap),
    .active_o   (h_active),
    .sync_win_o (h_sync_win)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (VW)
  ) u_v_axis (
    .clk_i      (sysclk),
    .clear_i    (halt),
    .count_en_i (tick & run_q & h_wrap),
    .count_o    (v_count),
    .wrap_o     (v_wrap),
    .active_o   (v_active),
    .sync_win_o (v_sync_win)
  );

  assign pix_valid = run_q & h_active & v_active;

`ifdef VGA_TESTPATTERN_EN
  // Bar index of the coordinate currently published; consumed at the next
  // tick, giving the same latency as rgb_in.
  logic [2:0] bar;
  assign bar = 3'({h_count, 3'b000} / (HW+3)'(H_ACTIVE));
`endif

  always_comb begin
    src = pix_t'(rgb_in);
`ifdef VGA_TESTPATTERN_EN
    if (pattern_sel) begin
      src.r = {COLOR_W{bar[2]}};
      src.g = {COLOR_W{bar[1]}};
      src.b = {COLOR_W{bar[0]}};
    end
`endif
  end

  always_comb begin
    div_d = div_q;
    run_d = run_q;
    fs_d  = 1'b0;
    col_d = col_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    if (halt) begin
      div_d = '0;
      run_d = 1'b0;
      col_d = '0;
      hs_d  = ~HS_POL;
      vs_d  = ~VS_POL;
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        run_d = 1'b1;
        // (0,0) is published either on restart or on the frame wrap
        fs_d  = ~run_q | (h_wrap & v_wrap);
        // outputs describe the coordinate that was on px_* until this edge
        col_d = pix_valid ? src : '0;
        hs_d  = (run_q & h_sync_win) ? HS_POL : ~HS_POL;
        vs_d  = (run_q & v_sync_win) ? VS_POL : ~VS_POL;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      div_q <= '0;
      run_q <= 1'b0;
      fs_q  <= 1'b0;
      col_q <= '0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
    end else begin
      div_q <= div_d;
      run_q <= run_d;
      fs_q  <= fs_d;
      col_q <= col_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign px_x        = h_count;
  assign px_y        = v_count;
  assign px_valid    = pix_valid;
  assign frame_start = fs_q;
  assign VGA_R       = col_q.r;
  assign VGA_G       = col_q.g;
  assign VGA_B       = col_q.b;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster generator driving the board's VGA connector from `sysclk`. Divides `sysclk` into a pixel tick and runs horizontal and vertical counters with fully parametrised porch, sync and polarity settings. Publishes the current pixel coordinate to an upstream pixel source and registers its multi-bit colour onto `VGA_R/G/B`, aligned with `VGA_HS/VGA_VS`. Replaces the fixed 640x480, 1-bit-per-channel driver path.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync, in lines
- HS_POL / VS_POL, 0 / 0, asserted sync level (0 = active-low)
- CLK_DIV, 2, sysclk cycles per pixel tick (>=1)
- COLOR_W, 1, bits per colour channel
- sysclk  in  1  system clock (50 MHz); one clock domain
- rst  in  1  synchronous, active-high reset
- enable  in  1  raster run; low restarts the raster
- rgb_in  in  3*COLOR_W  pixel colour {R,G,B} for the previously published coordinate
- pattern_sel  in  1  selects the internal test pattern (present only with VGA_TESTPATTERN_EN)
- px_x  out  clog2(H_TOTAL)  horizontal coordinate being requested
- px_y  out  clog2(V_TOTAL)  vertical coordinate being requested
- px_valid  out  1  px_x/px_y lie inside the active area
- frame_start  out  1  one-sysclk pulse at the tick where px_x=0, px_y=0
- VGA_R / VGA_G / VGA_B  out  COLOR_W each  registered colour
- VGA_HS / VGA_VS  out  1  registered sync outputs

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined likewise.
- Divider counts 0..CLK_DIV-1. A tick occurs in the cycle where the count equals CLK_DIV-1 (every cycle when CLK_DIV=1).
- Horizontal counter:
  - advances on each tick.
  - wraps from H_TOTAL-1 to 0.
- Vertical counter:
  - advances on the tick where the horizontal counter wraps.
  - wraps from V_TOTAL-1 to 0.
- Active region: h<H_ACTIVE and v<V_ACTIVE.
- HS window: H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. VS window uses the same form on v.
- In the sync window, the sync level is HS_POL/VS_POL. Outside it, the sync level is its inverse.
- Colour output:
  - on each tick, VGA_R/G/B load rgb_in if the previous coordinate was active; otherwise they load 0.
  - syncs are pipelined one tick so they stay aligned with colour.
- enable low: next edge clears the divider, counters and px_valid. Colour goes to 0 and syncs go inactive; this is held until enable returns high. The frame then restarts at (0,0).

## Timing
- Reset values:
  - divider, counters, px_x and px_y: 0
  - px_valid and frame_start: 0
  - VGA_R/G/B: 0
  - VGA_HS = ~HS_POL, VGA_VS = ~VS_POL
- px_x, px_y and px_valid update on the tick edge and are held for CLK_DIV cycles.
- rgb_in is sampled at the next tick edge, so the upstream source gets CLK_DIV cycles of lookup latency.
- VGA_R/G/B, VGA_HS and VGA_VS change together, exactly one tick after the corresponding px_* outputs.
- frame_start is high for one sysclk cycle only, on the edge where (0,0) is published.
- If rst and enable low coincide, rst wins; the resulting state is identical either way.
- Reset mid-line gives no partial sync pulse; syncs go inactive on the next edge.

## Configuration
- VGA_TESTPATTERN_EN defined:
  - adds pattern_sel.
  - with pattern_sel high, rgb_in is ignored and colour comes from 8 vertical bars. bar = (px_x*8)/H_ACTIVE; R=bar[2], G=bar[1], B=bar[0], each replicated to COLOR_W bits.
  - the pattern uses the same one-tick latency as rgb_in.
  - pattern_sel is sampled per tick, so switching mid-frame is legal.
- Undefined: pattern_sel is absent and colour always comes from rgb_in.

## Structure
- Shared package vga_pkg holds:
  - default timing constants for 640x480@60
  - function total(active,fp,sync,bp) and the clog2-based coordinate widths
  - the {R,G,B} colour struct, parametrised by COLOR_W
- One sub-module, vga_axis_counter, is instantiated twice (H and V). It has count, wrap, step-enable and sync-window compare, with inputs count_en and clear.

## Test plan
- Defaults, reset released, enable=1 -> frame_start every 840000 cycles. VGA_HS low for 192 cycles per 1600-cycle line, starting 2 cycles after the tick where px_x=656 is published.
- Defaults -> VGA_VS low for exactly lines 490-491 (3200 cycles). Colour is 0 whenever the source coordinate is outside 640x480.
- H_ACTIVE/FP/SYNC/BP=4/1/2/1, V=3/1/1/1, CLK_DIV=1, HS_POL=1, rgb_in=px_x (COLOR_W=1, masked) -> 48-cycle frame, HS high on h=5..6, colour follows coordinate with 1-cycle lag.
- enable dropped at px_x=300, px_y=100 for 10 cycles -> colour 0, syncs inactive. After release, (0,0) is republished with a frame_start pulse.
- rst asserted mid-VS for 1 cycle -> next cycle matches the reset values; no residual VS pulse.
- With VGA_TESTPATTERN_EN, pattern_sel=1, defaults -> colour {R,G,B} = 0 for x 0..79, then 1 for 80..159, up to 7 for 560..639; rgb_in has no effect.
